// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_pkg;

  typedef enum logic [2:0] {
    LOAD,
    SETTLE,
    RUN,
    CHECK,
    HALT
  } state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h00000000;
  localparam int          DEFAULT_DEPTH_LOG2 = 8;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction RAM: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int nbit       = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [nbit-1:0]       wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [nbit-1:0]       rdata
);

  logic [nbit-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from a valid/ready stream while holding the CPU in reset, then serves fetches.
// Optional LOAD_CHECKSUM_EN: a trailing checksum word must bring the running sum to zero.
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int nbit       = 32,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ld_valid,
  input  logic [nbit-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_ready,
  input  logic [nbit-1:0] PC,
  output logic [nbit-1:0] instr,
  output logic            cpu_reset_n,
  output logic            load_done,
  output logic            load_err,
  output logic            fetch_err
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(DEPTH - 1);

  state_t                state_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic                  ld_ready_reg;
  logic                  cpu_reset_n_reg;
  logic                  load_done_reg;
  logic                  load_err_reg;

  logic                  accept;
  logic                  mem_we;
  logic                  at_end;
  logic [DEPTH_LOG2-1:0] rd_index;
  logic [nbit-1:0]       rd_data;
  logic                  pc_bad;
  logic                  running;

  assign accept = ld_valid & ld_ready_reg;
  assign mem_we = accept & (state_reg == LOAD);
  // A full RAM ends the load just like ld_last; only the missing ld_last makes it an error.
  assign at_end = ld_last | (wr_ptr_reg == LAST_ADDR);

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] sum_reg;
  logic [31:0] sum_total;
  assign sum_total = sum_reg + 32'(ld_data);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= LOAD;
      wr_ptr_reg      <= '0;
      ld_ready_reg    <= 1'b1;
      cpu_reset_n_reg <= 1'b0;
      load_done_reg   <= 1'b0;
      load_err_reg    <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      sum_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        LOAD: begin
          if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
`ifdef LOAD_CHECKSUM_EN
            sum_reg    <= sum_total;
`endif
            if (at_end) begin
              if (!ld_last) begin
                load_err_reg <= 1'b1;
              end
`ifdef LOAD_CHECKSUM_EN
              state_reg    <= CHECK;
`else
              state_reg    <= SETTLE;
              ld_ready_reg <= 1'b0;
`endif
            end
          end
        end
        SETTLE: begin
          state_reg       <= RUN;
          cpu_reset_n_reg <= 1'b1;
          load_done_reg   <= 1'b1;
        end
`ifdef LOAD_CHECKSUM_EN
        // The checksum word is consumed here and never written to RAM.
        CHECK: begin
          if (accept) begin
            ld_ready_reg <= 1'b0;
            if (sum_total == 32'd0) begin
              state_reg <= SETTLE;
            end else begin
              state_reg    <= HALT;
              load_err_reg <= 1'b1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  imem_array #(
    .nbit      (nbit),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_reg),
    .wdata(ld_data),
    .raddr(rd_index),
    .rdata(rd_data)
  );

  assign rd_index = PC[DEPTH_LOG2+1:2];
  assign pc_bad   = (PC[1:0] != 2'b00) | (PC[nbit-1:DEPTH_LOG2+2] != '0);
  assign running  = (state_reg == RUN);

  assign fetch_err   = running & pc_bad;
  assign instr       = (running & ~pc_bad) ? rd_data : nbit'(NOP_INSTR);
  assign ld_ready    = ld_ready_reg;
  assign cpu_reset_n = cpu_reset_n_reg;
  assign load_done   = load_done_reg;
  assign load_err    = load_err_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: per-cycle model comparison plus directed literal checks.
module tb_instr_mem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [31:0] PC = 32'd0;
  logic [31:0] instr;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_err;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [31:0] tb_sum = 32'd0;

  // Model: words accepted so far, edges since the load terminated (-1 = still loading)
  logic [31:0] m_mem [0:DEPTH-1];
  bit          m_written [0:DEPTH-1];
  int          m_wr = 0;
  int          m_since = -1;
  bit          m_err = 1'b0;
  bit          m_chk = 1'b0;
  bit          m_halt = 1'b0;
  logic [31:0] m_sum = 32'd0;

  bit          e_run;
  bit          e_pc_ok;
  int          e_idx;

  instr_mem_loader #(
    .nbit      (32),
    .DEPTH_LOG2(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .PC         (PC),
    .instr      (instr),
    .cpu_reset_n(cpu_reset_n),
    .load_done  (load_done),
    .load_err   (load_err),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_wr    <= 0;
      m_since <= -1;
      m_err   <= 1'b0;
      m_chk   <= 1'b0;
      m_halt  <= 1'b0;
      m_sum   <= 32'd0;
    end else begin
      if (m_since >= 0 && m_since < 3) m_since <= m_since + 1;
      if (ld_valid && m_since < 0 && !m_halt) begin
        if (m_chk) begin
          $display("ACCEPT checksum data=%h", ld_data);
          m_chk <= 1'b0;
          if (m_sum + ld_data == 32'd0) m_since <= 0;
          else begin
            m_halt <= 1'b1;
            m_err  <= 1'b1;
          end
        end else begin
          $display("ACCEPT word idx=%0d data=%h last=%0d", m_wr, ld_data, ld_last);
          m_mem[m_wr]     <= ld_data;
          m_written[m_wr] <= 1'b1;
          m_wr            <= m_wr + 1;
          m_sum           <= m_sum + ld_data;
          if (ld_last || m_wr == DEPTH - 1) begin
            if (!ld_last) m_err <= 1'b1;
`ifdef LOAD_CHECKSUM_EN
            m_chk <= 1'b1;
`else
            m_since <= 0;
`endif
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en && reset_n) begin
      e_run   = (m_since >= 1);
      e_pc_ok = (PC % 4 == 0) && (PC < 32'd1024);
      e_idx   = int'(PC / 4);
      check("cyc_ld_ready", 32'(ld_ready), 32'(m_since < 0 && !m_halt));
      check("cyc_cpu_reset_n", 32'(cpu_reset_n), 32'(e_run));
      check("cyc_load_done", 32'(load_done), 32'(e_run));
      check("cyc_load_err", 32'(load_err), 32'(m_err));
      check("cyc_fetch_err", 32'(fetch_err), 32'(e_run && !e_pc_ok));
      if (!(e_run && e_pc_ok)) check("cyc_instr_nop", instr, 32'd0);
      else if (m_written[e_idx]) check("cyc_instr", instr, m_mem[e_idx]);
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      ld_data  = 32'hBAD0_0000 + 32'(g);
      ld_last  = 1'b0;
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tb_sum   = tb_sum + d;
  endtask

  task automatic end_load();
`ifdef LOAD_CHECKSUM_EN
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = -tb_sum;
    ld_last  = 1'b0;
`endif
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tb_sum   = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !load_done; i++) @(negedge clk);
    check("load_done_wait", 32'(load_done), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    @(negedge clk);
    PC = a;
    #1;
    check("fetch_instr", instr, ei);
    check("fetch_err", 32'(fetch_err), 32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Three-word program, ld_valid held high
    send_word(32'h20080005, 1'b0, 0);
    send_word(32'h20090003, 1'b0, 0);
    send_word(32'h01095020, 1'b1, 0);
`ifndef LOAD_CHECKSUM_EN
    @(posedge clk); #2;
    check("ready_drop", 32'(ld_ready), 32'd0);
    check("cpu_held_settle", 32'(cpu_reset_n), 32'd0);
    @(posedge clk); #2;
    check("cpu_release", 32'(cpu_reset_n), 32'd1);
    check("done_release", 32'(load_done), 32'd1);
`endif
    end_load();
    wait_done(20);
    fetch(32'h0, 32'h20080005, 1'b0);
    fetch(32'h4, 32'h20090003, 1'b0);
    fetch(32'h8, 32'h01095020, 1'b0);
    fetch(32'h6, 32'h0, 1'b1);
    fetch(32'h400, 32'h0, 1'b1);

    // Alternating valid: only handshaked words land
    do_reset();
    send_word(32'h11111111, 1'b0, 0);
    send_word(32'h22222222, 1'b0, 1);
    send_word(32'h33333333, 1'b1, 1);
    end_load();
    wait_done(20);
    fetch(32'h0, 32'h11111111, 1'b0);
    fetch(32'h4, 32'h22222222, 1'b0);
    fetch(32'h8, 32'h33333333, 1'b0);

    // Overflow: 256 words without ld_last, then junk offered after the load ends
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(32'hA000_0000 + 32'(i), 1'b0, 0);
`ifdef LOAD_CHECKSUM_EN
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = -tb_sum;
`endif
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 32'hDEADBEEF;
      ld_last  = 1'b0;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    wait_done(20);
    check("ovf_load_err", 32'(load_err), 32'd1);
    check("ovf_cpu_run", 32'(cpu_reset_n), 32'd1);
    fetch(32'h0, 32'hA0000000, 1'b0);
    fetch(32'h3FC, 32'hA00000FF, 1'b0);
    fetch(32'h400, 32'h0, 1'b1);

    // Asynchronous reset mid-run, then a one-word reload
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("midrst_ld_ready", 32'(ld_ready), 32'd1);
    check("midrst_load_done", 32'(load_done), 32'd0);
    check("midrst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tb_sum  = 32'd0;
    send_word(32'h12345678, 1'b1, 0);
    end_load();
    wait_done(20);
    fetch(32'h0, 32'h12345678, 1'b0);
    fetch(32'h4, 32'hA0000001, 1'b0);

`ifdef LOAD_CHECKSUM_EN
    do_reset();
    send_word(32'h1, 1'b0, 0);
    send_word(32'h2, 1'b1, 0);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = 32'hFFFFFFFD;
    ld_last  = 1'b0;
    @(negedge clk);
    ld_valid = 1'b0;
    wait_done(20);
    check("cks_ok_err", 32'(load_err), 32'd0);
    fetch(32'h8, 32'hA0000002, 1'b0);

    do_reset();
    send_word(32'h1, 1'b0, 0);
    send_word(32'h2, 1'b1, 0);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = 32'h0;
    @(negedge clk);
    ld_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("cks_bad_err", 32'(load_err), 32'd1);
    check("cks_bad_cpu", 32'(cpu_reset_n), 32'd0);
    check("cks_bad_ready", 32'(ld_ready), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
